// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: a small FIFO of {pc, instr} pairs between fetch and decode.
// Handshakes come from registered occupancy only, so there is no ready/valid path through the queue.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_instr,
    output logic                     if_ready,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] instr_mem_d [DEPTH];

    logic push;
    logic pop;

    assign if_ready = (count_q < CW'(DEPTH));
    assign id_valid = (count_q != '0);
    assign count    = count_q;
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;

    // Empty queue presents a NOP at pc 0 so decode never sees stale storage.
    assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : NOP;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = if_pc;
                instr_mem_d[wr_ptr_q] = if_instr;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus queues expected pairs, a negedge monitor checks every pop.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst, flush, if_valid, id_ready;
    logic [XLEN-1:0] if_pc, if_instr;
    logic            if_ready, id_valid;
    logic [XLEN-1:0] id_pc, id_instr;
    logic [1:0]      count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    pair_t exp_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    pop_cnt = 0;

    if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A0_0093;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc, input bit expect_accept);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr_of(pc);
        if (expect_accept) exp_q.push_back({pc, instr_of(pc)});
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && id_valid && id_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got pc %h with no entry expected", id_pc);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                check("pop_pc", id_pc, e.pc);
                check("pop_instr", id_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_instr = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_count", 32'(count), 32'd0);

        // single push, 1-cycle latency, held while id_ready low
        if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'h0050_0093;
        exp_q.push_back({32'h0, 32'h0050_0093});
        tick();
        if_valid = 1'b0;
        check("one_id_valid", 32'(id_valid), 32'd1);
        check("one_id_pc", id_pc, 32'h0);
        check("one_id_instr", id_instr, 32'h0050_0093);
        check("one_count", 32'(count), 32'd1);
        tick();
        check("hold_id_instr", id_instr, 32'h0050_0093);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("one_drain_count", 32'(count), 32'd0);

        // fill to full, third push refused, then drain in order
        drive_push(32'h0, 1'b1); tick();
        drive_push(32'h4, 1'b1); tick();
        check("full_count", 32'(count), 32'd2);
        check("full_if_ready", 32'(if_ready), 32'd0);
        drive_push(32'h8, 1'b0); tick();
        if_valid = 1'b0;
        check("full_ignore_count", 32'(count), 32'd2);
        id_ready = 1'b1;
        tick();
        check("pop1_if_ready", 32'(if_ready), 32'd1);
        check("pop1_count", 32'(count), 32'd1);
        tick();
        id_ready = 1'b0;
        check("drain_id_valid", 32'(id_valid), 32'd0);
        check("drain_id_instr", id_instr, 32'h0000_0013);

        // streaming push+pop across pointer wrap
        drive_push(32'h0, 1'b1); tick();
        drive_push(32'h4, 1'b1); tick();
        if_valid = 1'b0; id_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            drive_push(32'h8 + 32'(4 * i), 1'b1);
            tick();
            check("stream_count", 32'(count), 32'd1);
        end
        if_valid = 1'b0;
        tick();
        id_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // flush with concurrent push and pop
        drive_push(32'h40, 1'b1); tick();
        drive_push(32'h44, 1'b1); tick();
        check("preflush_count", 32'(count), 32'd2);
        flush = 1'b1; id_ready = 1'b1;
        drive_push(32'h100, 1'b0);
        tick();
        flush = 1'b0; id_ready = 1'b0; if_valid = 1'b0;
        exp_q.delete();
        check("flush_count", 32'(count), 32'd0);
        check("flush_id_valid", 32'(id_valid), 32'd0);
        check("flush_id_instr", id_instr, 32'h0000_0013);
        check("flush_if_ready", 32'(if_ready), 32'd1);
        drive_push(32'h200, 1'b1); tick();
        if_valid = 1'b0;
        check("postflush_id_valid", 32'(id_valid), 32'd1);
        check("postflush_id_pc", id_pc, 32'h200);
        check("postflush_count", 32'(count), 32'd1);
        id_ready = 1'b1; tick(); id_ready = 1'b0;

        // reset beats flush, push and pop
        drive_push(32'h300, 1'b1); tick();
        check("prerst_count", 32'(count), 32'd1);
        rst = 1'b1; flush = 1'b1; id_ready = 1'b1;
        drive_push(32'h304, 1'b0);
        tick();
        rst = 1'b0; flush = 1'b0; id_ready = 1'b0; if_valid = 1'b0;
        exp_q.delete();
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_if_ready", 32'(if_ready), 32'd1);
        check("midrst_id_valid", 32'(id_valid), 32'd0);
        check("midrst_id_pc", id_pc, 32'h0);
        tick(); tick();
        check("midrst_stays_empty", 32'(id_valid), 32'd0);

        check("total_pops", 32'(pop_cnt), 32'd12);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of IF/ID entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32, PC and instruction width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-006 SHALL have port if_valid  input  1  fetch stage presents a {pc, instr} pair.
REQ-007 SHALL have port if_pc  input  XLEN  PC of the fetched instruction (PC register output).
REQ-008 SHALL have port if_instr  input  XLEN  fetched instruction word.
REQ-009 SHALL have port if_ready  output  1  queue accepts a pair this cycle; drives the PC register write enable.
REQ-010 SHALL have port id_valid  output  1  head entry is valid for decode.
REQ-011 SHALL have port id_ready  input  1  decode consumes the head entry this cycle.
REQ-012 SHALL have port id_pc  output  XLEN  PC of the head entry.
REQ-013 SHALL have port id_instr  output  XLEN  instruction of the head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of held entries.

Function
REQ-015 SHALL define push = if_valid & if_ready and pop = id_valid & id_ready; no other condition changes occupancy except flush and rst.
REQ-016 SHALL drive if_ready = (count < DEPTH), from registered state only; no combinational path from id_ready or if_valid.
REQ-017 SHALL drive id_valid = (count != 0), from registered state only.
REQ-018 SHALL present the head entry on id_pc/id_instr combinationally from storage; when count = 0, id_pc = 0 and id_instr = 32'h00000013 (NOP).
REQ-019 SHALL have latency exactly 1 cycle: a pair pushed in cycle N is visible on id_* with id_valid = 1 in cycle N+1 (no bypass).
REQ-020 SHALL keep id_pc/id_instr stable while id_valid = 1 and id_ready = 0.
REQ-021 SHALL write the pushed pair at the write pointer and advance it modulo DEPTH; pop SHALL advance the read pointer modulo DEPTH; both pointers wrap DEPTH-1 -> 0.
REQ-022 SHALL update count: push only +1; pop only -1; push and pop same cycle unchanged, both entries handled in order.
REQ-023 SHALL ignore if_valid when full (if_ready = 0); the fetch stage holds the PC because if_ready is low.
REQ-024 SHALL ignore id_ready when empty (id_valid = 0).
REQ-025 SHALL, on flush = 1, set count = 0 and both pointers = 0 in the next cycle; any push or pop in the flush cycle is discarded (flush has priority over push and pop).
REQ-026 SHALL accept a push in the cycle after flush (if_ready = 1 once count = 0).
REQ-027 SHALL preserve FIFO order: entries are presented to ID in push order, no duplication or loss except by flush/rst.

Reset
REQ-028 SHALL, when rst = 1 at a rising edge, set count = 0, write and read pointers = 0; rst has priority over flush, push and pop.
REQ-029 SHALL, after reset, show if_ready = 1, id_valid = 0, id_pc = 0, id_instr = 32'h00000013; storage contents need not be reset.
REQ-030 SHALL, on rst asserted mid-operation with entries held, drop all entries at that edge; no held entry appears on id_* afterwards.

Verification
REQ-031 Reset then push {pc=0x0, instr=0x00500093} with id_ready=0 -> next cycle id_valid=1, id_pc=0x0, id_instr=0x00500093, count=1.
REQ-032 Push 0x0, 0x4, 0x8 on consecutive cycles, id_ready=0 (DEPTH=2) -> count=2, if_ready=0 after second push, 0x8 not accepted; then id_ready=1 -> id_pc 0x0 then 0x4, if_ready=1 after first pop.
REQ-033 Full queue, push 0x8 and pop same cycle once if_ready=1, streamed for 6 cycles -> pointers wrap, id_pc sequence 0x0,0x4,0x8,0xC,... with no gaps or repeats, count constant.
REQ-034 count=2, assert flush with if_valid=1 (pc=0x100) and id_ready=1 -> next cycle count=0, id_valid=0, id_instr=0x00000013; 0x100 not stored; push 0x200 following cycle -> id_pc=0x200 one cycle later.
REQ-035 count=1, assert rst with flush=1, if_valid=1 and id_ready=1 -> next cycle count=0, if_ready=1, id_valid=0, id_pc=0.
